lsu_pipe: RTL and testbench

- Parametrised load/store unit between execute stage and data memory port.
- Accepts one memory op per valid/ready handshake and drives a req/gnt/rvalid data-memory bus with byte enables.
- Aligns store data to byte lanes; extracts, sign- or zero-extends load data.
- Returns a registered writeback (rd, data) to the register file; supports up to OUTSTANDING in-flight loads.

---
 rtl/lsu_pkg.sv | 69 ++++++
 rtl/lsu_track_fifo.sv | 53 +++++
 rtl/lsu_pipe.sv | 185 ++++++++++++++++++
 tb/tb_lsu_pipe.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM states, tracking entry and lane helpers for lsu_pipe.
// Build option LSU_MISALIGN_TRAP_EN is consumed by lsu_pipe.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       uns;
      logic [2:0] off;
   } trk_t;

   function automatic logic [3:0] size_bytes(logic [1:0] size);
      logic [3:0] n;
      unique case (size)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] be_mask(logic [1:0] size, logic [2:0] off);
      logic [7:0] m;
      unique case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   // Replicating the operand puts it on every lane, so any offset lines up.
   function automatic logic [63:0] store_lanes(logic [63:0] d, logic [1:0] size);
      logic [63:0] r;
      unique case (size)
         SZ_B:    r = {8{d[7:0]}};
         SZ_H:    r = {4{d[15:0]}};
         SZ_W:    r = {2{d[31:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] load_extend(logic [63:0] d, logic [1:0] size,
                                               logic [2:0] off, logic uns);
      logic [63:0] s;
      logic [63:0] r;
      s = d >> {off, 3'b000};
      unique case (size)
         SZ_B:    r = {{56{s[7] & ~uns}}, s[7:0]};
         SZ_H:    r = {{48{s[15] & ~uns}}, s[15:0]};
         SZ_W:    r = {{32{s[31] & ~uns}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_track_fifo.sv
// lsu_track_fifo: in-order queue of issued memory requests awaiting rvalid.
// A push and a pop in the same cycle are legal even when full.
module lsu_track_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] ram [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = ram[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else begin
         if (do_push) begin
            ram[wr_ptr] <= push_data;
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit driving a req/gnt/rvalid data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned ops instead of aligning them.
module lsu_pipe
   import lsu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int OUTSTANDING = 2,
   parameter int RD_W        = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [RD_W-1:0]     req_rd,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                wb_valid,
   output logic [RD_W-1:0]     wb_rd,
   output logic [XLEN-1:0]     wb_data,
   output logic                lsu_busy,
   output logic                err_misalign
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int TW    = $bits(trk_t) + RD_W;
   localparam int CW    = $clog2(OUTSTANDING + 1);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            run;
   logic            rdy;
   logic            accept;
   logic            trap;
   logic            issue_ok;
   logic            gnt_fire;
   logic            pop_ok;
   logic [1:0]      sz_eff;
   logic [2:0]      off_raw;
   logic [2:0]      align_m;
   logic [2:0]      off_al;
   trk_t            r_trk;
   trk_t            hd_trk;
   logic [RD_W-1:0] r_rd;
   logic [RD_W-1:0] hd_rd;
   logic [TW-1:0]   head;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [CW-1:0]   cnt_nxt;
   logic            full_nxt;

   assign sz_eff  = (XLEN == 32 && req_size == SZ_D) ? SZ_W : req_size;
   assign off_raw = 3'(req_addr[OFF_W-1:0]);
   assign align_m = 3'(size_bytes(sz_eff) - 4'd1);
   assign off_al  = off_raw & ~align_m;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = |(off_raw & align_m);
`else
   assign trap = 1'b0;
`endif

   assign accept   = req_valid & req_ready;
   assign issue_ok = accept & ~trap;
   assign gnt_fire = (state == ST_ISSUE) & mem_gnt;
   assign pop_ok   = mem_rvalid & ~empty;
   assign mem_req  = (state == ST_ISSUE);
   assign lsu_busy = (state != ST_IDLE) | (count != '0);

   assign {hd_trk, hd_rd} = head;

   lsu_track_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (TW),
      .CW    (CW)
   ) u_trk (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (gnt_fire),
      .push_data ({r_trk, r_rd}),
      .pop       (mem_rvalid),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      cnt_nxt = count;
      if (gnt_fire && !pop_ok)
         cnt_nxt = count + CW'(1);
      else if (!gnt_fire && pop_ok)
         cnt_nxt = count - CW'(1);
   end

   assign full_nxt = (cnt_nxt == CW'(OUTSTANDING));

   // Ready during a grant lets the next op land without a bubble.
   always_comb begin
      rdy = 1'b0;
      unique case (state)
         ST_IDLE:  rdy = ~full;
         ST_ISSUE: rdy = mem_gnt & ~full_nxt;
         default:  rdy = 1'b0;
      endcase
   end

   assign req_ready = run & rdy;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (issue_ok) state_nxt = ST_ISSUE;
         ST_ISSUE:
            if (mem_gnt) begin
               if (full_nxt)      state_nxt = ST_STALL;
               else if (issue_ok) state_nxt = ST_ISSUE;
               else               state_nxt = ST_IDLE;
            end
         ST_STALL:
            if (pop_ok) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         r_trk     <= '0;
         r_rd      <= '0;
      end else if (issue_ok) begin
         mem_we    <= req_we;
         mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         mem_be    <= NB'(be_mask(sz_eff, off_al));
         mem_wdata <= XLEN'(store_lanes(64'(req_wdata), sz_eff));
         r_trk     <= '{we: req_we, size: sz_eff, uns: req_unsigned, off: off_al};
         r_rd      <= req_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         err_misalign <= 1'b0;
      end else begin
         err_misalign <= accept & trap;
         wb_valid     <= pop_ok & ~hd_trk.we;
         if (pop_ok && !hd_trk.we) begin
            wb_rd   <= hd_rd;
            wb_data <= XLEN'(load_extend(64'(mem_rdata), hd_trk.size,
                                         hd_trk.off, hd_trk.uns));
         end
      end
   end

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed and randomized checks of lsu_pipe against a queue model.
`timescale 1ns/1ps
module tb_lsu_pipe;
   localparam int XLEN = 32;
   localparam int AW   = 32;
   localparam int OUT  = 2;
   localparam int RDW  = 5;
   localparam int NB   = XLEN / 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_we = 1'b0;
   logic [1:0]      req_size = '0;
   logic            req_unsigned = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [XLEN-1:0] req_wdata = '0;
   logic [RDW-1:0]  req_rd = '0;
   logic            mem_req;
   logic            mem_gnt = 1'b0;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [NB-1:0]   mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rvalid = 1'b0;
   logic [XLEN-1:0] mem_rdata = '0;
   logic            wb_valid;
   logic [RDW-1:0]  wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            lsu_busy;
   logic            err_misalign;

   always #5 clk = ~clk;

   lsu_pipe #(
      .XLEN(XLEN), .ADDR_W(AW), .OUTSTANDING(OUT), .RD_W(RDW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .lsu_busy(lsu_busy), .err_misalign(err_misalign)
   );

   typedef struct {
      bit             we;
      int             size;
      bit             uns;
      logic [31:0]    addr;
      logic [31:0]    wdata;
      logic [RDW-1:0] rd;
   } op_t;

   typedef struct {
      op_t op;
      int  due;
   } fl_t;

   op_t src_q[$];
   op_t iss_q[$];
   fl_t fl_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int gnt_pct = 70;
   int lat_min = 1;
   int lat_max = 6;
   int stall_cycles = 0;
   bit acc_last = 1'b0;
   bit pend_wb = 1'b0;
   bit exp_err = 1'b0;
   logic [RDW-1:0] pend_rd;
   logic [31:0]    pend_data;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(int size);
      if (size == 0) return 1;
      if (size == 1) return 2;
      return 4;
   endfunction

   function automatic bit misaligned(op_t o);
      return (int'(o.addr[1:0]) % nbytes(o.size)) != 0;
   endfunction

   function automatic int eff_off(op_t o);
      int a;
      a = int'(o.addr[1:0]);
      return a - (a % nbytes(o.size));
   endfunction

   function automatic logic [31:0] exp_load(op_t o, logic [31:0] rdata);
      int nb;
      logic [63:0] v;
      logic [63:0] m;
      nb = nbytes(o.size);
      v = 64'(rdata) >> (eff_off(o) * 8);
      m = (64'd1 << (nb * 8)) - 64'd1;
      v = v & m;
      if (!o.uns && v[nb*8-1]) v = v | ~m;
      return v[31:0];
   endfunction

   function automatic op_t mk_op(bit we, int size, bit uns, logic [31:0] addr,
                                 logic [31:0] wdata, logic [RDW-1:0] rd);
      op_t o;
      o.we = we; o.size = size; o.uns = uns;
      o.addr = addr; o.wdata = wdata; o.rd = rd;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.we    = $urandom_range(0, 2) == 0;
      o.size  = $urandom_range(0, 3);
      o.uns   = $urandom_range(0, 1) == 1;
      o.addr  = $urandom;
      o.wdata = $urandom;
      o.rd    = RDW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0)
         o.addr = o.addr & ~32'(nbytes(o.size) - 1);
      return o;
   endfunction

   task automatic drive_op(op_t o);
      req_we       = o.we;
      req_size     = 2'(o.size);
      req_unsigned = o.uns;
      req_addr     = o.addr;
      req_wdata    = o.wdata;
      req_rd       = o.rd;
   endtask

   task automatic check_grant(op_t o);
      int off;
      int nb;
      logic [3:0] ebe;
      off = eff_off(o);
      nb  = nbytes(o.size);
      ebe = 4'(((1 << nb) - 1) << off);
      check("g_addr", mem_addr, o.addr & 32'hFFFF_FFFC);
      check("g_be", mem_be, ebe);
      check("g_we", mem_we, o.we);
      if (o.we) begin
         for (int l = 0; l < NB; l++) begin
            if (ebe[l]) check("g_lane", mem_wdata[l*8 +: 8], o.wdata[(l-off)*8 +: 8]);
         end
      end
   endtask

   // One clock of the randomized engine: drive at negedge, observe 1ns later.
   task automatic step();
      op_t o;
      fl_t f;
      @(negedge clk);
      cyc++;
      if (acc_last) begin
         req_valid = 1'b0;
         acc_last  = 1'b0;
      end
      if (!req_valid && src_q.size() > 0 && $urandom_range(0, 4) != 0) begin
         drive_op(src_q[0]);
         req_valid = 1'b1;
      end
      mem_gnt    = $urandom_range(0, 99) < gnt_pct;
      mem_rvalid = fl_q.size() > 0 && fl_q[0].due <= cyc;
      mem_rdata  = $urandom;
      #1;
      check("wb_valid", wb_valid, pend_wb);
      if (pend_wb) begin
         check("wb_rd", wb_rd, pend_rd);
         check("wb_data", wb_data, pend_data);
      end
      check("err", err_misalign, exp_err);
      pend_wb = 1'b0;
      exp_err = 1'b0;
      if (mem_rvalid) begin
         f = fl_q.pop_front();
         if (!f.op.we) begin
            pend_wb   = 1'b1;
            pend_rd   = f.op.rd;
            pend_data = exp_load(f.op, mem_rdata);
         end
      end
      if (mem_req && mem_gnt) begin
         if (iss_q.size() == 0) begin
            check("spurious_req", 1, 0);
         end else begin
            o = iss_q.pop_front();
            check_grant(o);
            f.op  = o;
            f.due = cyc + $urandom_range(lat_min, lat_max);
            fl_q.push_back(f);
            check("max_outstanding", fl_q.size() <= OUT, 1);
         end
      end
      if (req_valid && req_ready) begin
         o = src_q.pop_front();
         acc_last = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
         if (misaligned(o)) exp_err = 1'b1;
         else begin
            check("accept_room", fl_q.size() < OUT, 1);
            iss_q.push_back(o);
         end
`else
         check("accept_room", fl_q.size() < OUT, 1);
         iss_q.push_back(o);
`endif
      end else if (req_valid) begin
         stall_cycles++;
      end
   endtask

   task automatic dir_load(logic [31:0] addr, int size, bit uns, logic [RDW-1:0] rd,
                           logic [31:0] rdata, logic [31:0] exp);
      @(negedge clk);
      drive_op(mk_op(1'b0, size, uns, addr, 32'h0, rd));
      req_valid = 1'b1;
      mem_gnt   = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      #1 check("ld_req", mem_req, 1);
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      #1 check("ld_wb_early", wb_valid, 0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("ld_wb_valid", wb_valid, 1);
      check("ld_wb_rd", wb_rd, rd);
      check("ld_wb_data", wb_data, exp);
      @(negedge clk);
      #1 check("ld_wb_pulse", wb_valid, 0);
   endtask

   int guard;

   initial begin
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_outs", {mem_req, mem_we, mem_be, mem_addr, wb_valid, lsu_busy, err_misalign}, 0);
      check("rst_wb", {wb_rd, wb_data, mem_wdata}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check("ready_after_rst", req_ready, 1);

      // store byte with a slow grant
      @(negedge clk);
      drive_op(mk_op(1'b1, 0, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0));
      req_valid = 1'b1;
      mem_gnt   = 1'b0;
      #1 check("st_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("st_req", mem_req, 1);
      check("st_addr", mem_addr, 32'h1000);
      check("st_be", mem_be, 4'b1000);
      check("st_wdata", mem_wdata, 32'hABAB_ABAB);
      check("st_we", mem_we, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("hold_req", mem_req, 1);
         check("hold_bus", {mem_addr, mem_be}, {32'h1000, 4'b1000});
         check("hold_wdata", mem_wdata, 32'hABAB_ABAB);
      end
      @(negedge clk);
      mem_gnt = 1'b1;
      #1 check("st_req5", mem_req, 1);
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      check("st_granted", mem_req, 0);
      check("st_busy", lsu_busy, 1);
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("st_no_wb", wb_valid, 0);
      check("st_idle", lsu_busy, 0);

      dir_load(32'h2002, 1, 1'b0, 5'd7, 32'h8001_1234, 32'hFFFF_8001);
      dir_load(32'h2001, 0, 1'b1, 5'd9, 32'h0000_F200, 32'h0000_00F2);

      // misaligned word load
      @(negedge clk);
      drive_op(mk_op(1'b0, 2, 1'b0, 32'h3002, 32'h0, 5'd3));
      req_valid = 1'b1;
      #1 check("mis_ready", req_ready, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("mis_err", err_misalign, 1);
      check("mis_no_req", mem_req, 0);
      @(negedge clk);
      #1;
      check("mis_err_pulse", err_misalign, 0);
      check("mis_no_req2", mem_req, 0);
      check("mis_no_wb", wb_valid, 0);
`else
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      #1;
      check("mis_err", err_misalign, 0);
      check("mis_req", mem_req, 1);
      check("mis_aligned", {mem_addr, mem_be}, {32'h3000, 4'b1111});
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1122_3344;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("mis_wb", {wb_valid, wb_data}, {1'b1, 32'h1122_3344});
`endif

      // three loads, immediate grant, fixed slow return
      gnt_pct = 100; lat_min = 5; lat_max = 5; stall_cycles = 0;
      src_q.push_back(mk_op(1'b0, 2, 1'b0, 32'h5000, 32'h0, 5'd1));
      src_q.push_back(mk_op(1'b0, 2, 1'b0, 32'h5004, 32'h0, 5'd2));
      src_q.push_back(mk_op(1'b0, 2, 1'b0, 32'h5008, 32'h0, 5'd3));
      for (int i = 0; i < 30; i++) step();
      check("stall_seen", stall_cycles > 0, 1);
      check("three_done", src_q.size() + iss_q.size() + fl_q.size(), 0);

      // randomized traffic
      gnt_pct = 70; lat_min = 1; lat_max = 6;
      for (int i = 0; i < 300; i++) src_q.push_back(rand_op());
      guard = 0;
      while (src_q.size() > 0 && guard < 5000) begin
         step();
         guard++;
      end
      guard = 0;
      while ((iss_q.size() > 0 || fl_q.size() > 0) && guard < 200) begin
         step();
         guard++;
      end
      step();
      check("drain", src_q.size() + iss_q.size() + fl_q.size(), 0);
      check("drain_busy", lsu_busy, 0);

      // reset while a load waits for its data
      @(negedge clk);
      drive_op(mk_op(1'b0, 0, 1'b0, 32'h4001, 32'h0, 5'd12));
      req_valid = 1'b1;
      mem_gnt   = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1 check("mid_busy", lsu_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
      check("mid_rst_wdata", mem_wdata, 0);
      check("mid_rst_wb", {wb_valid, wb_rd, wb_data}, 0);
      check("mid_rst_ctl", {req_ready, lsu_busy, err_misalign}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check("ghost_wb", wb_valid, 0);
      check("ghost_busy", lsu_busy, 0);
      check("ghost_ready", req_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
